// File: rtl/noc_input_port_if.sv
// Input-port bundle: upstream flit push with FULL backpressure, allocator req/grant, status.
// master = the input port itself, slave = the upstream sender and allocator side.
interface noc_input_port_if #(
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] data_in;
  logic                  data_valid_in;
  logic                  full_out;
  logic [DATA_WIDTH-1:0] flit_out;
  logic                  out_req;
  logic [4:0]            out_port;
  logic                  out_grant;
  logic                  route_busy;
  logic                  proto_err;
  logic [7:0]            drop_cnt;

  modport master (
    input  data_in, data_valid_in, out_grant,
    output full_out, flit_out, out_req, out_port, route_busy, proto_err, drop_cnt
  );

  modport slave (
    output data_in, data_valid_in, out_grant,
    input  full_out, flit_out, out_req, out_port, route_busy, proto_err, drop_cnt
  );
endinterface

// File: rtl/noc_input_port.sv
// Router input port: flit FIFO + XY route held per wormhole packet; write-to-out_req latency 1 cycle, no bypass.
// Backpressure: full_out when DEPTH flits held; writes at full without a same-cycle pop are dropped and counted.
module noc_input_port #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4,
  parameter int XW         = 2,
  parameter int YW         = 1,
  parameter int MY_X       = 0,
  parameter int MY_Y       = 0
) (
  input  logic             clk,
  input  logic             rst,
  noc_input_port_if.master port
);
  localparam int AW = $clog2(DEPTH);

  localparam logic [1:0] T_BODY   = 2'b00;
  localparam logic [1:0] T_HEAD   = 2'b01;
  localparam logic [1:0] T_TAIL   = 2'b10;
  localparam logic [1:0] T_SINGLE = 2'b11;

  localparam logic [4:0] P_LOCAL = 5'b00001;
  localparam logic [4:0] P_EAST  = 5'b00010;
  localparam logic [4:0] P_WEST  = 5'b00100;
  localparam logic [4:0] P_NORTH = 5'b01000;
  localparam logic [4:0] P_SOUTH = 5'b10000;

  typedef enum logic {IDLE, ROUTED} state_t;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr, rd_ptr;
  logic [AW:0]           count, count_nxt;
  state_t                state;
  logic [4:0]            route_q;
  logic                  proto_err_q;
  logic [7:0]            drop_q;

  logic [DATA_WIDTH-1:0] head;
  logic [1:0]            head_type;
  logic [XW-1:0]         dst_x;
  logic [YW-1:0]         dst_y;
  logic                  nonempty, full, head_legal, req, pop, discard, adv, wr_en, overflow;
  logic [4:0]            route_comb;

  assign nonempty  = (count != '0);
  assign full      = (count == (AW+1)'(DEPTH));
  assign head      = mem[rd_ptr];
  assign head_type = head[DATA_WIDTH-1 -: 2];
  assign dst_x     = head[DATA_WIDTH-3 -: XW];
  assign dst_y     = head[DATA_WIDTH-3-XW -: YW];

  // Legality depends on where we are in the packet; illegal heads are silently drained.
  assign head_legal = (state == IDLE) ? (head_type == T_HEAD || head_type == T_SINGLE)
                                      : (head_type == T_BODY || head_type == T_TAIL);
  assign req      = nonempty && head_legal;
  assign pop      = req && port.out_grant;
  assign discard  = nonempty && !head_legal;
  assign adv      = pop || discard;
  assign wr_en    = port.data_valid_in && (!full || pop);
  assign overflow = port.data_valid_in && full && !pop;

  always_comb begin
    route_comb = P_LOCAL;
    if (int'(dst_x) > MY_X)      route_comb = P_EAST;
    else if (int'(dst_x) < MY_X) route_comb = P_WEST;
    else if (int'(dst_y) > MY_Y) route_comb = P_SOUTH;
    else if (int'(dst_y) < MY_Y) route_comb = P_NORTH;
  end

  always_comb begin
    count_nxt = count;
    if (wr_en && !adv)      count_nxt = count + (AW+1)'(1);
    else if (!wr_en && adv) count_nxt = count - (AW+1)'(1);
  end

  // Storage carries no reset so it can map onto a plain register file.
  always_ff @(posedge clk) begin
    if (wr_en && !rst) mem[wr_ptr] <= port.data_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      state       <= IDLE;
      route_q     <= '0;
      proto_err_q <= 1'b0;
      drop_q      <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (adv)   rd_ptr <= rd_ptr + AW'(1);
      count       <= count_nxt;
      proto_err_q <= discard;
      if (overflow && drop_q != 8'hFF) drop_q <= drop_q + 8'd1;
      case (state)
        IDLE: begin
          if (pop && head_type == T_HEAD) begin
            state   <= ROUTED;
            route_q <= route_comb;
          end
        end
        ROUTED: begin
          if (pop && head_type == T_TAIL) begin
            state   <= IDLE;
            route_q <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign port.full_out   = full;
  assign port.flit_out   = nonempty ? head : '0;
  assign port.out_req    = req;
  assign port.out_port   = !req ? 5'b00000 : ((state == IDLE) ? route_comb : route_q);
  assign port.route_busy = (state == ROUTED);
  assign port.proto_err  = proto_err_q;
  assign port.drop_cnt   = drop_q;
endmodule
